// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// -----------------------------------------------------------------------------
// Captures the architectural write stream of the pipelined core as trace
// records and buffers them in program order for a debug/monitor consumer.
//   - GRF writes (WB stage) and DM writes (MEM stage) each become one record.
//   - A GRF write to register 0 is architecturally invisible and is filtered.
//   - In one cycle the GRF record is older than the DM record and is stored
//     first; records that do not fit are dropped and counted.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   defined   : 32-bit free-running cycle counter, per-record stamp, out_ts port
//   undefined : no counter, no stamp storage, no out_ts port
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 4)
//   CNT_W  width of the saturating drop counter
//
// Ports
//   clk, reset                     clock; asynchronous active-high reset
//   grf_we/pc/addr/wdata           WB-stage register-file write
//   dm_we/pc/addr/wdata            MEM-stage data-memory write
//   out_valid/out_ready            drain handshake for the head record
//   out_type/pc/addr/data[/ts]     head record (all zero when out_valid = 0)
//   overflow                       sticky: at least one record was dropped
//   drop_cnt                       dropped-record count, saturating
//   level                          current occupancy (0..DEPTH)
//
// Handshake: out_valid is high whenever a record is buffered and does not
// depend on out_ready. A record is consumed on a posedge where both out_valid
// and out_ready are high; while out_valid = 1 and out_ready = 0 the head and
// all out_* fields hold. out_ready while out_valid = 0 is ignored.
// -----------------------------------------------------------------------------
module commit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       grf_we,
    input  logic [31:0]                grf_pc,
    input  logic [4:0]                 grf_addr,
    input  logic [31:0]                grf_wdata,
    input  logic                       dm_we,
    input  logic [31:0]                dm_pc,
    input  logic [31:0]                dm_addr,
    input  logic [31:0]                dm_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_type,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
`ifdef TRACE_TIMESTAMP_EN
    output logic [31:0]                out_ts,
`endif
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic        rtype;   // 0 = GRF, 1 = DM
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
`ifdef TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } rec_t;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]      ts_cnt;
`endif

    logic             grf_ev;
    logic             dm_ev;
    logic [LVL_W-1:0] free;
    logic [1:0]       n_ev;
    logic [1:0]       n_push;
    logic [1:0]       n_drop;
    logic             pop;
    rec_t             grf_rec;
    rec_t             dm_rec;
    rec_t             rec0;
    rec_t             head;
    logic [CNT_W:0]   drop_sum;

    // Event decode and record assembly.
    always_comb begin
        grf_ev = grf_we && (grf_addr != 5'd0);
        dm_ev  = dm_we;

        grf_rec       = '0;
        grf_rec.rtype = 1'b0;
        grf_rec.pc    = grf_pc;
        grf_rec.addr  = {27'b0, grf_addr};
        grf_rec.data  = grf_wdata;

        dm_rec        = '0;
        dm_rec.rtype  = 1'b1;
        dm_rec.pc     = dm_pc;
        dm_rec.addr   = dm_addr;
        dm_rec.data   = dm_wdata;

`ifdef TRACE_TIMESTAMP_EN
        grf_rec.ts    = ts_cnt;
        dm_rec.ts     = ts_cnt;
`endif

        // The first stored record is the oldest present event.
        rec0 = grf_ev ? grf_rec : dm_rec;
    end

    // Push/drop resolution. Capacity is taken from the occupancy before this
    // cycle's pop, so a simultaneous pop never makes room for a push.
    always_comb begin
        free   = LVL_W'(DEPTH) - level;
        n_ev   = {1'b0, grf_ev} + {1'b0, dm_ev};
        n_push = 2'd0;
        if (free == '0) begin
            n_push = 2'd0;
        end else if (free == LVL_W'(1)) begin
            n_push = (n_ev != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            n_push = n_ev;
        end
        n_drop = n_ev - n_push;
        pop    = out_valid && out_ready;
    end

    // One extra bit catches the carry; two drops at most, so any carry means
    // the count went past all-ones and is clamped there.
    always_comb begin
        drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, n_drop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            level  <= level + LVL_W'(n_push) - LVL_W'(pop);
            if (n_drop != 2'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
            end
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= 32'd0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end
`endif

    // Storage carries no reset: occupancy alone decides what is valid.
    // Two pushes only happen when both events are present, so slot 0 gets
    // the GRF record and slot 1 the DM record.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (n_push != 2'd0) begin
                mem[wr_ptr] <= rec0;
            end
            if (n_push == 2'd2) begin
                mem[PTR_W'(wr_ptr + PTR_W'(1))] <= dm_rec;
            end
        end
    end

    // Head presentation; fields are forced to zero when nothing is buffered.
    always_comb begin
        out_valid = (level != '0);
        head      = out_valid ? mem[rd_ptr] : '0;
        out_type  = head.rtype;
        out_pc    = head.pc;
        out_addr  = head.addr;
        out_data  = head.data;
`ifdef TRACE_TIMESTAMP_EN
        out_ts    = head.ts;
`endif
    end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo
// Directed steps followed by randomized traffic, each cycle compared against a
// queue-based model of the trace FIFO. A small drop counter width is used so
// saturation is reached within the run.
module tb_commit_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int W     = 129;   // {type, pc, addr, data, ts}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              grf_we;
    logic [31:0]       grf_pc;
    logic [4:0]        grf_addr;
    logic [31:0]       grf_wdata;
    logic              dm_we;
    logic [31:0]       dm_pc;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic              out_valid;
    logic              out_ready;
    logic              out_type;
    logic [31:0]       out_pc;
    logic [31:0]       out_addr;
    logic [31:0]       out_data;
    logic [31:0]       ts_obs;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic [LVL_W-1:0]  level;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] out_ts;
    assign ts_obs = out_ts;
`else
    assign ts_obs = 32'd0;
`endif

    commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .grf_we    (grf_we),
        .grf_pc    (grf_pc),
        .grf_addr  (grf_addr),
        .grf_wdata (grf_wdata),
        .dm_we     (dm_we),
        .dm_pc     (dm_pc),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_type  (out_type),
        .out_pc    (out_pc),
        .out_addr  (out_addr),
        .out_data  (out_data),
`ifdef TRACE_TIMESTAMP_EN
        .out_ts    (out_ts),
`endif
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .level     (level)
    );

    // ---------------- scoreboard / model state ----------------
    logic [W-1:0] exp_q[$];
    int           m_drop;
    logic         m_ovf;
    logic [31:0]  m_ts;
    int           checks;
    int           errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        m_ts   = 32'd0;
    endtask

    // One clock of the trace rules: capacity is what was free before the
    // edge; the head leaves if the consumer was ready; events are stored
    // oldest first until capacity runs out, the rest are dropped.
    task automatic model_cycle(
        input logic gwe, input logic [31:0] gpc, input logic [4:0] gaddr, input logic [31:0] gdata,
        input logic dwe, input logic [31:0] dpc, input logic [31:0] daddr, input logic [31:0] ddata,
        input logic rdy);
        logic [W-1:0] ev[$];
        int cap;
        if (gwe && gaddr != 5'd0) ev.push_back({1'b0, gpc, {27'b0, gaddr}, gdata, m_ts});
        if (dwe)                  ev.push_back({1'b1, dpc, daddr, ddata, m_ts});
        cap = DEPTH - exp_q.size();
        if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        for (int k = 0; k < ev.size(); k++) begin
            if (k < cap) begin
                exp_q.push_back(ev[k]);
            end else begin
                m_ovf  = 1'b1;
                m_drop = (m_drop + 1 > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : m_drop + 1;
            end
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic check_all();
        logic [W-1:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("valid",    {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
        chk("type",     {31'b0, out_type},  {31'b0, h[128]});
        chk("pc",       out_pc,             h[127:96]);
        chk("addr",     out_addr,           h[95:64]);
        chk("data",     out_data,           h[63:32]);
`ifdef TRACE_TIMESTAMP_EN
        chk("ts",       ts_obs,             h[31:0]);
`endif
        chk("level",    32'(level),         32'(exp_q.size()));
        chk("overflow", {31'b0, overflow},  {31'b0, m_ovf});
        chk("drop_cnt", 32'(drop_cnt),      32'(m_drop));
    endtask

    // ---------------- driver ----------------
    task automatic step(
        input logic gwe, input logic [31:0] gpc, input logic [4:0] gaddr, input logic [31:0] gdata,
        input logic dwe, input logic [31:0] dpc, input logic [31:0] daddr, input logic [31:0] ddata,
        input logic rdy);
        grf_we = gwe; grf_pc = gpc; grf_addr = gaddr; grf_wdata = gdata;
        dm_we  = dwe; dm_pc  = dpc; dm_addr  = daddr; dm_wdata  = ddata;
        out_ready = rdy;
        @(posedge clk);
        model_cycle(gwe, gpc, gaddr, gdata, dwe, dpc, daddr, ddata, rdy);
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] ts0;
        checks = 0;
        errors = 0;
        ts0    = 32'd0;
        model_reset();
        reset = 1'b1;
        grf_we = 1'b0; grf_pc = '0; grf_addr = '0; grf_wdata = '0;
        dm_we = 1'b0; dm_pc = '0; dm_addr = '0; dm_wdata = '0;
        out_ready = 1'b0;
        #12;
        reset = 1'b0;
        #1;
        check_all();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);

        // single GRF record, then drained
        step(1'b1, 32'h3000, 5'd8, 32'h1234, 1'b0, '0, '0, '0, 1'b0);
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_addr",  out_addr, 32'd8);
        chk("t1_data",  out_data, 32'h1234);
        idle(1'b1);
        chk("t1_level", 32'(level), 32'd0);

        // GRF and DM in one cycle: GRF first
        step(1'b1, 32'h3004, 5'd9, 32'h5555, 1'b1, 32'h3008, 32'h10, 32'hAB, 1'b0);
        chk("t2_level", 32'(level), 32'd2);
        chk("t2_pc",    out_pc, 32'h3004);
        idle(1'b1);
        chk("t2_type",  {31'b0, out_type}, 32'd1);
        chk("t2_daddr", out_addr, 32'h10);
        idle(1'b1);

        // write to register 0 is filtered, not a drop
        step(1'b1, 32'h300C, 5'd0, 32'hFFFF, 1'b0, '0, '0, '0, 1'b0);
        chk("t3_level", 32'(level), 32'd0);
        chk("t3_ovf",   {31'b0, overflow}, 32'd0);

        // fill to 15, then both events with one free slot
        for (int i = 0; i < 15; i++) begin
            if (i % 2 == 0)
                step(1'b1, 32'h4000 + 32'(4*i), 5'(i % 31 + 1), $urandom, 1'b0, '0, '0, '0, 1'b0);
            else
                step(1'b0, '0, 5'd0, '0, 1'b1, 32'h4000 + 32'(4*i), $urandom, $urandom, 1'b0);
        end
        step(1'b1, 32'h5000, 5'd3, 32'h33, 1'b1, 32'h5004, 32'h20, 32'h44, 1'b0);
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_ovf",   {31'b0, overflow}, 32'd1);
        chk("t4_drop",  32'(drop_cnt), 32'd1);

        // full: pop and event in the same cycle, event still dropped
        step(1'b1, 32'h5008, 5'd4, 32'h55, 1'b0, '0, '0, '0, 1'b1);
        chk("t5_level", 32'(level), 32'd15);
        chk("t5_drop",  32'(drop_cnt), 32'd2);
        for (int i = 0; i < 15; i++) idle(1'b1);

        // asynchronous reset between edges with 5 records buffered
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h6000 + 32'(4*i), 5'd5, 32'(i), 1'b0, '0, '0, '0, 1'b0);
        chk("t6_pre", 32'(level), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("t6_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        #1;
        reset = 1'b0;

        // stamps of records pushed 3 cycles apart
        step(1'b1, 32'h7000, 5'd6, 32'h1, 1'b0, '0, '0, '0, 1'b0);
        ts0 = ts_obs;
        idle(1'b0);
        idle(1'b0);
        step(1'b0, '0, 5'd0, '0, 1'b1, 32'h7004, 32'h40, 32'h2, 1'b0);
        idle(1'b1);
`ifdef TRACE_TIMESTAMP_EN
        chk("t7_tsdiff", ts_obs - ts0, 32'd3);
`endif
        idle(1'b1);

        // randomized traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 600; i++) begin
            logic rdy;
            rdy = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, rdy);
        end

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
